// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester round-robin arbiter in front of the single
//                off-chip line memory port. Port 0 is the instruction-cache
//                refill path, port 1 the data-cache writeback/refill path.
//                Only one memory transaction is in flight at a time.
//
//  Ports
//    clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//    pX_req_i            request, held by the requester until pX_ack_o
//    pX_write_i          1 = write line, 0 = read line
//    pX_addr_i           line address
//    pX_data_i           write data
//    pX_ack_o            one-cycle completion pulse
//    pX_data_o           read data, qualified by pX_ack_o
//    mem_enable_o        memory request, held for the whole transaction
//    mem_write_o         memory write strobe
//    mem_addr_o          memory address
//    mem_data_o          memory write data
//    mem_data_i          memory read data
//    mem_ack_i           memory completion pulse
//    grant_o             one-hot current owner (00 = none)
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_req_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,

    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT0    = 2'd1,
        GNT1    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // 0 = port 0 owned the last transaction, 1 = port 1 did.
    logic   r_last_grant;
    logic   w_next_last_grant;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            IDLE: begin
                if (p0_req_i && p1_req_i) begin
                    // Contention: hand the port to whoever did not own it last.
                    if (r_last_grant) begin
                        w_next_state      = GNT0;
                        w_next_last_grant = 1'b0;
                    end else begin
                        w_next_state      = GNT1;
                        w_next_last_grant = 1'b1;
                    end
                end else if (p0_req_i) begin
                    w_next_state      = GNT0;
                    w_next_last_grant = 1'b0;
                end else if (p1_req_i) begin
                    w_next_state      = GNT1;
                    w_next_last_grant = 1'b1;
                end
            end
            // A requester dropping req mid-transaction is ignored: memory
            // transactions cannot be aborted, so only mem_ack_i ends them.
            GNT0: if (mem_ack_i) w_next_state = RELEASE;
            GNT1: if (mem_ack_i) w_next_state = RELEASE;
            // One dead cycle so the memory always sees a fresh enable edge and
            // the requester has a cycle to drop its req.
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output mux: decoded straight from the state register so an asynchronous
    // reset zeroes every output immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        p0_ack_o     = 1'b0;
        p1_ack_o     = 1'b0;
        grant_o      = 2'b00;
        case (r_state)
            GNT0: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p0_write_i;
                mem_addr_o   = p0_addr_i;
                mem_data_o   = p0_data_i;
                p0_ack_o     = mem_ack_i;
                grant_o      = 2'b01;
            end
            GNT1: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p1_write_i;
                mem_addr_o   = p1_addr_i;
                mem_data_o   = p1_data_i;
                p1_ack_o     = mem_ack_i;
                grant_o      = 2'b10;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each requester qualifies it with its own ack.
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Requesters push the
//                expected outcome of each transaction into per-port queues; a
//                monitor pops and compares on every ack and checks the
//                round-robin owner, the dead cycle and the grant latency
//                against a small behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         p0_req = 0, p0_write = 0, p1_req = 0, p1_write = 0;
    logic [31:0]  p0_addr = 0, p1_addr = 0;
    logic [255:0] p0_wdata = 0, p1_wdata = 0;
    logic         p0_ack, p1_ack;
    logic [255:0] p0_rdata, p1_rdata;
    logic         mem_enable, mem_write, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic [1:0]   grant;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(256)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_write_i(p0_write), .p0_addr_i(p0_addr),
        .p0_data_i(p0_wdata), .p0_ack_o(p0_ack), .p0_data_o(p0_rdata),
        .p1_req_i(p1_req), .p1_write_i(p1_write), .p1_addr_i(p1_addr),
        .p1_data_i(p1_wdata), .p1_ack_o(p1_ack), .p1_data_o(p1_rdata),
        .mem_enable_o(mem_enable), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .grant_o(grant)
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   gnt_log[$];
    int   checks = 0;
    int   failures = 0;

    bit   auto_mem  = 1'b1;
    int   fixed_lat = 0;

    function automatic logic [255:0] rd_of(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    task automatic chk(input bit ok, input string name,
                       input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Memory responder: acks after a latency counted in enabled cycles.
    // ------------------------------------------------------------------------
    initial begin
        int cnt = 0;
        int lat = 1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_mem) begin
                mem_ack   = 1'b0;
                mem_rdata = {8{$urandom}};
                if (rst || !mem_enable) begin
                    cnt = 0;
                end else begin
                    cnt++;
                    if (cnt == 1) lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
                    if (cnt >= lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd_of(mem_addr);
                        cnt       = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin
        logic [1:0] prev_req   = 2'b00;
        logic [1:0] prev_grant = 2'b00;
        bit         prev_rel   = 1'b0;
        bit         prev_valid = 1'b0;
        bit         last_ack   = 1'b0;
        bit         model_last = 1'b1;
        bit         rel_now;
        int         exp_owner;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk(grant == 2'b00 && !mem_enable && !p0_ack && !p1_ack && mem_addr == 0,
                    "reset_outputs", {grant, mem_enable, p0_ack, p1_ack}, 0);
                model_last = 1'b1;
                prev_valid = 1'b0;
                prev_grant = 2'b00;
                prev_rel   = 1'b0;
                last_ack   = 1'b0;
            end else begin
                rel_now = last_ack;
                // A request seen in a true idle cycle must be granted next cycle.
                if (prev_valid && prev_grant == 2'b00 && !prev_rel && prev_req != 2'b00)
                    chk(grant != 2'b00, "grant_latency", grant, prev_req);
                // Exactly one dead cycle after every completed transaction.
                if (rel_now)
                    chk(grant == 2'b00 && !mem_enable, "release_gap", {grant, mem_enable}, 0);
                // New owner must follow round-robin from the requests just seen.
                if (prev_grant == 2'b00 && grant != 2'b00) begin
                    if (prev_req == 2'b11)      exp_owner = model_last ? 0 : 1;
                    else if (prev_req == 2'b01) exp_owner = 0;
                    else if (prev_req == 2'b10) exp_owner = 1;
                    else                        exp_owner = -1;
                    chk(exp_owner >= 0 && grant == (2'b01 << exp_owner), "rr_owner",
                        grant, (exp_owner >= 0) ? (2'b01 << exp_owner) : 0);
                    if (exp_owner >= 0) model_last = (exp_owner == 1);
                    gnt_log.push_back(grant == 2'b10 ? 1 : 0);
                end
                if (grant == 2'b00) begin
                    chk(!mem_enable && !mem_write && mem_addr == 0 && mem_wdata == 0 &&
                        !p0_ack && !p1_ack, "idle_outputs",
                        {mem_enable, mem_write, p0_ack, p1_ack}, 0);
                end else begin
                    chk(mem_enable && (grant == 2'b01 || grant == 2'b10), "busy_enable",
                        {grant, mem_enable}, 1);
                end
                for (int p = 0; p < 2; p++) begin
                    if (p == 0 ? p0_ack : p1_ack) begin
                        if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                            chk(1'b0, "unexpected_ack", p, 0);
                        end else begin
                            e = (p == 0) ? q0.pop_front() : q1.pop_front();
                            chk(grant == (2'b01 << p), "ack_owner", grant, 2'b01 << p);
                            chk(mem_write == e.wr, "ack_write", mem_write, e.wr);
                            chk(mem_addr == e.addr, "ack_addr", mem_addr, e.addr);
                            chk(mem_wdata == e.wdata, "ack_wdata", mem_wdata, e.wdata);
                            chk((p == 0 ? p0_rdata : p1_rdata) == e.rdata, "ack_rdata",
                                (p == 0 ? p0_rdata : p1_rdata), e.rdata);
                            chk(!(p == 0 ? p1_ack : p0_ack), "ack_exclusive", 1, 0);
                        end
                    end
                end
                last_ack   = p0_ack | p1_ack;
                prev_rel   = rel_now;
                prev_grant = grant;
                prev_valid = 1'b1;
            end
            prev_req = {p1_req, p0_req};
        end
    end

    // ------------------------------------------------------------------------
    // Requester helpers (called at posedge+1)
    // ------------------------------------------------------------------------
    task automatic drive(input int p, input bit req, input bit wr,
                         input logic [31:0] a, input logic [255:0] d);
        if (p == 0) begin p0_req = req; p0_write = wr; p0_addr = a; p0_wdata = d; end
        else        begin p1_req = req; p1_write = wr; p1_addr = a; p1_wdata = d; end
    endtask

    task automatic set_req(input int p, input bit req);
        if (p == 0) p0_req = req; else p1_req = req;
    endtask

    task automatic push_exp(input int p, input bit wr, input logic [31:0] a,
                            input logic [255:0] d);
        exp_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.rdata = rd_of(a);
        if (p == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic wait_ack(input int p);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (p == 0 ? p0_ack : p1_ack) begin ok = 1'b1; break; end
        end
        if (!ok) chk(1'b0, "ack_timeout", p, 1);
    endtask

    task automatic wait_grant(input logic [1:0] g);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (grant == g) begin ok = 1'b1; break; end
        end
        if (!ok) chk(1'b0, "grant_timeout", grant, g);
    endtask

    task automatic do_txn(input int p, input bit wr, input logic [31:0] a,
                          input logic [255:0] d, input int gap);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        push_exp(p, wr, a, d);
        drive(p, 1'b1, wr, a, d);
        wait_ack(p);
        @(posedge clk);
        #1;
        set_req(p, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int s;
        repeat (2) @(posedge clk);
        #1;
        chk(grant == 0 && !mem_enable && !p0_ack && !p1_ack, "reset_state", grant, 0);
        rst = 1'b0;

        // 1: lone p0 read, memory latency 10
        fixed_lat = 10;
        @(posedge clk); #1;
        push_exp(0, 1'b0, 32'h400, '0);
        drive(0, 1'b1, 1'b0, 32'h400, '0);
        @(negedge clk);
        chk(!mem_enable, "t1_enable_not_yet", mem_enable, 0);
        @(negedge clk);
        chk(mem_enable && mem_addr == 32'h400 && !mem_write, "t1_enable_rise",
            {mem_enable, mem_write, mem_addr}, {1'b1, 1'b0, 32'h400});
        wait_ack(0);
        @(posedge clk); #1;
        set_req(0, 1'b0);

        // 2: simultaneous requests after reset -> port 0 first, then port 1
        fixed_lat = 3;
        do_reset();
        s = gnt_log.size();
        fork
            do_txn(0, 1'b0, 32'h2000, {8{32'h1111_0000}}, 0);
            do_txn(1, 1'b0, 32'h3000, {8{32'h2222_0000}}, 0);
        join
        chk(gnt_log.size() == s + 2 && gnt_log[s] == 0 && gnt_log[s+1] == 1, "t2_order",
            gnt_log.size() - s, 2);

        // 3: both hold req for six transactions -> strict alternation from port 0
        fixed_lat = 0;
        s = gnt_log.size();
        fork
            begin for (int i = 0; i < 3; i++) do_txn(0, 1'b0, 32'h100 * (i + 1), '0, 0); end
            begin for (int i = 0; i < 3; i++) do_txn(1, 1'b1, 32'h8000 + 32'h20 * i, {8{$urandom}}, 0); end
        join
        chk(gnt_log.size() == s + 6, "t3_count", gnt_log.size() - s, 6);
        for (int k = 0; k < 6 && s + k < gnt_log.size(); k++)
            chk(gnt_log[s+k] == (k % 2), "t3_alternate", gnt_log[s+k], k % 2);

        // 4: p1 line write, then a spurious memory ack while idle
        do_txn(1, 1'b1, 32'h1000, {8{32'hDEADBEEF}}, 1);
        repeat (2) @(posedge clk);
        auto_mem = 1'b0;
        #1 mem_ack = 1'b1;
        @(negedge clk);
        chk(!p0_ack && !p1_ack && grant == 0, "t4_spurious_ack", {p0_ack, p1_ack, grant}, 0);
        @(posedge clk); #1 mem_ack = 1'b0;
        auto_mem = 1'b1;
        @(negedge clk);
        chk(grant == 0 && !mem_enable, "t4_state_kept", {grant, mem_enable}, 0);

        // 5: p0 drops req mid-transaction; transaction still runs to mem_ack
        fixed_lat = 8;
        @(posedge clk); #1;
        push_exp(0, 1'b0, 32'h4400, '0);
        drive(0, 1'b1, 1'b0, 32'h4400, '0);
        wait_grant(2'b01);
        @(posedge clk); #1;
        set_req(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(mem_enable && grant == 2'b01, "t5_hold_enable", {grant, mem_enable}, 3'b011);
        end
        wait_ack(0);
        @(negedge clk);
        chk(grant == 0 && !mem_enable, "t5_release", {grant, mem_enable}, 0);

        // 6: asynchronous reset during GNT1, then tie -> port 0
        fixed_lat = 20;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h7000, '0);
        wait_grant(2'b10);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk(grant == 0 && !mem_enable && mem_addr == 0 && !p1_ack, "t6_async_reset",
            {grant, mem_enable}, 0);
        drive(0, 1'b1, 1'b0, 32'h6000, '0);
        fixed_lat = 4;
        push_exp(0, 1'b0, 32'h6000, '0);
        push_exp(1, 1'b0, 32'h7000, '0);
        s = gnt_log.size();
        @(posedge clk); #3;
        rst = 1'b0;
        wait_ack(0);
        chk(gnt_log.size() > s && gnt_log[s] == 0, "t6_tie_port0",
            (gnt_log.size() > s) ? gnt_log[s] : -1, 0);
        @(posedge clk); #1;
        set_req(0, 1'b0);
        wait_ack(1);
        @(posedge clk); #1;
        set_req(1, 1'b0);

        // Random traffic on both ports with random memory latency
        fixed_lat = 0;
        fork
            begin
                for (int i = 0; i < 15; i++)
                    do_txn(0, 1'($urandom), $urandom & 32'hFFFF_FFE0,
                           {8{$urandom}}, int'($urandom_range(0, 3)));
            end
            begin
                for (int i = 0; i < 15; i++)
                    do_txn(1, 1'($urandom), $urandom & 32'hFFFF_FFE0,
                           {8{$urandom}}, int'($urandom_range(0, 3)));
            end
        join

        repeat (4) @(posedge clk);
        chk(q0.size() == 0 && q1.size() == 0, "scoreboard_drained", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
